serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
UART receive engine for the serial peripheral. It consumes the 16x oversample tick produced by the baud divider path and deserialises the rx line into 5–8-bit words, LSB first, with optional parity. Each completed word is presented on a valid/ready holding register together with framing, parity, overrun and break status for the AXI register block.

Parameters:
OVERSAMPLE, 16, sampleTick pulses per bit period; must be an even number ≥ 4.
SYNC_STAGES, 2, number of flops in the rx metastability synchroniser.

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  receiver enable; low aborts any frame in progress and forces IDLE
sampleTick  input  1  one-clock pulse at OVERSAMPLE × baud rate
rx  input  1  asynchronous serial line; idle level is 1
wordLength  input  2  00=5, 01=6, 10=7, 11=8 data bits
parityEnable  input  1  a parity bit follows the data bits
parityOdd  input  1  1=odd parity, 0=even parity
rxData  output  8  received word, right-aligned, unused upper bits 0
rxValid  output  1  rxData and flags hold a word
rxReady  input  1  consumer accepts the word when rxValid & rxReady
parityError  output  1  qualified by rxValid
framingError  output  1  qualified by rxValid; stop bit sampled 0
breakDetect  output  1  qualified by rxValid; all bits including stop sampled 0
overrunError  output  1  one-clock pulse; a completed word was dropped
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchroniser flops =1, state=IDLE, counters=0, rxData=0, rxValid=0, all flags=0, busy=0.
- Config inputs are sampled on the start-detect tick and held for the whole frame.
- The FSM advances only on clocks where sampleTick=1; tickCount is a 0..OVERSAMPLE-1 counter.
- IDLE: a tick with synchronised rx=0 → START, tickCount←0.
- START: at tickCount=OVERSAMPLE/2-1, sample rx. 0 → DATA, tickCount←0, bitIndex←0. 1 → false start, return to IDLE with no output.
- DATA: at tickCount=OVERSAMPLE-1, shift the sample into bit bitIndex, tickCount←0. After the last data bit, go to PARITY if parityEnable, otherwise STOP.
- PARITY: sample at tickCount=OVERSAMPLE-1. Error if XOR(data bits, parity bit) ≠ parityOdd.
- STOP: sample at tickCount=OVERSAMPLE-1, then deliver the word in the next clock (see Delivery).
  - Stop=1 → IDLE.
  - Stop=0 → framingError=1.
  - Stop=0 and all data and parity samples are 0 → breakDetect=1, framingError=1, and go to BREAK_WAIT.
  - Stop=0 without break → IDLE.
- BREAK_WAIT: stay until a tick sees rx=1, then go to IDLE. No start detect while in this state.
- Delivery:
  - If rxValid=0, or rxValid=1 with rxReady=1 in the same clock, load rxData and all three flags and set rxValid=1.
  - Otherwise keep the old word and flags and pulse overrunError for one clock.
- Handshake:
  - rxValid falls the clock after rxValid & rxReady, unless a new word loads in that same clock, in which case it stays 1.
  - rxData and the flags are stable while rxValid=1.
- enable=0: the FSM goes to IDLE the next clock and any partial frame is discarded. The holding register and rxValid are unaffected.
- Reset mid-frame: everything returns to reset values next clock, including a pending word.
- Latency: rxValid rises exactly 1 clock after the stop-bit sampling tick.

Test Plan:
- sampleTick every clock, 8N1, rx sends 0xA5 → rxData=0xA5, rxValid rises 8+16·9 clocks after the start edge is synchronised, all flags 0, busy falls with it.
- 7E1 sending 0x41 with correct parity 0 → no error. Repeat with parity bit flipped → rxData=0x41, parityError=1. Same in 7O1 with parity bit 1 → no error.
- A 4-tick rx low glitch in IDLE → back to IDLE at the mid-start tick, rxValid stays 0, busy pulses.
- 8N1 frame 0x3C with stop=0 → framingError=1, breakDetect=0. A 20-bit-time low → rxData=0x00, breakDetect=1, framingError=1. No further word until rx returns high and a new start bit arrives.
- Two back-to-back words with rxReady=0 → first word kept, overrunError pulses once. Then rxReady=1 held on the same clock the next word completes → new word loads, rxValid stays 1, no overrun.
- Reset asserted at bit 4 of a frame, then a fresh 5N1 frame 0x15 → clean reset values, then rxData=0x15 with upper bits 0. Separately, enable low mid-frame → no word delivered, and the held word survives.

Source files
------------

// File: rtl/serial_receiver.sv
// UART receive engine: 16x-oversampled deserialiser for 5-8 bit words,
// optional parity, valid/ready holding register with error/break status.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   enable                   low aborts any frame in progress and forces IDLE
//   sampleTick               one-clock pulse at OVERSAMPLE x baud
//   rx                       asynchronous serial line, idle high
//   wordLength               00=5, 01=6, 10=7, 11=8 data bits
//   parityEnable, parityOdd  parity bit present / odd (1) or even (0)
//   rxData, rxValid, rxReady received word and its valid/ready handshake
//   parityError              status of the held word, qualified by rxValid
//   framingError             status of the held word, qualified by rxValid
//   breakDetect              status of the held word, qualified by rxValid
//   overrunError             one-clock pulse when a completed word is dropped
//   busy                     receiver is in any state other than IDLE
module serial_receiver #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       sampleTick,
   input  logic       rx,
   input  logic [1:0] wordLength,
   input  logic       parityEnable,
   input  logic       parityOdd,
   output logic [7:0] rxData,
   output logic       rxValid,
   input  logic       rxReady,
   output logic       parityError,
   output logic       framingError,
   output logic       breakDetect,
   output logic       overrunError,
   output logic       busy
);

   localparam int TW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } state_t;

   state_t          state, state_n;
   logic [SYNC_STAGES-1:0] sync;
   logic            rxs;
   logic [TW-1:0]   tick, tick_n;
   logic [2:0]      bitIdx, bit_n;
   logic [7:0]      shift, shift_n;
   logic [1:0]      cfgLen, len_n;
   logic            cfgPe, pe_n;
   logic            cfgOdd, odd_n;
   logic            parErr, par_n;
   logic            allZero, zero_n;
   logic            done;
   logic [2:0]      lastBit;
   logic            tickMid, tickEnd;

   // pending word: captured on the stop tick, offered to the holding
   // register on the following clock
   logic            pendValid;
   logic [7:0]      pendData;
   logic            pendPar, pendFrm, pendBrk;

   assign rxs     = sync[SYNC_STAGES-1];
   assign lastBit = {1'b0, cfgLen} + 3'd4;
   assign tickMid = (tick == TW'(OVERSAMPLE/2 - 1));
   assign tickEnd = (tick == TW'(OVERSAMPLE - 1));
   assign busy    = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         sync    <= '1;
         state   <= IDLE;
         tick    <= '0;
         bitIdx  <= '0;
         shift   <= '0;
         cfgLen  <= '0;
         cfgPe   <= 1'b0;
         cfgOdd  <= 1'b0;
         parErr  <= 1'b0;
         allZero <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], rx};
         state   <= state_n;
         tick    <= tick_n;
         bitIdx  <= bit_n;
         shift   <= shift_n;
         cfgLen  <= len_n;
         cfgPe   <= pe_n;
         cfgOdd  <= odd_n;
         parErr  <= par_n;
         allZero <= zero_n;
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick;
      bit_n   = bitIdx;
      shift_n = shift;
      len_n   = cfgLen;
      pe_n    = cfgPe;
      odd_n   = cfgOdd;
      par_n   = parErr;
      zero_n  = allZero;
      done    = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         tick_n  = '0;
      end else if (sampleTick) begin
         unique case (state)
            IDLE: begin
               if (!rxs) begin
                  state_n = START;
                  tick_n  = '0;
                  len_n   = wordLength;
                  pe_n    = parityEnable;
                  odd_n   = parityOdd;
                  shift_n = '0;
                  par_n   = 1'b0;
                  zero_n  = 1'b1;
               end
            end
            START: begin
               if (tickMid) begin
                  tick_n  = '0;
                  bit_n   = '0;
                  state_n = rxs ? IDLE : DATA;
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
            DATA: begin
               if (tickEnd) begin
                  tick_n          = '0;
                  shift_n[bitIdx] = rxs;
                  zero_n          = allZero & ~rxs;
                  if (bitIdx == lastBit) begin
                     state_n = cfgPe ? PARITY : STOP;
                  end else begin
                     bit_n = bitIdx + 1'b1;
                  end
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
            PARITY: begin
               if (tickEnd) begin
                  tick_n  = '0;
                  par_n   = ((^shift) ^ rxs) != cfgOdd;
                  zero_n  = allZero & ~rxs;
                  state_n = STOP;
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
            STOP: begin
               if (tickEnd) begin
                  tick_n  = '0;
                  done    = 1'b1;
                  state_n = (!rxs && allZero) ? BREAK_WAIT : IDLE;
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
            BREAK_WAIT: begin
               if (rxs) begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pendValid    <= 1'b0;
         pendData     <= '0;
         pendPar      <= 1'b0;
         pendFrm      <= 1'b0;
         pendBrk      <= 1'b0;
         rxData       <= '0;
         rxValid      <= 1'b0;
         parityError  <= 1'b0;
         framingError <= 1'b0;
         breakDetect  <= 1'b0;
         overrunError <= 1'b0;
      end else begin
         pendValid    <= done;
         overrunError <= 1'b0;
         if (done) begin
            pendData <= shift;
            pendPar  <= parErr;
            pendFrm  <= ~rxs;
            pendBrk  <= ~rxs & allZero;
         end
         if (pendValid) begin
            if (!rxValid || rxReady) begin
               rxData       <= pendData;
               parityError  <= pendPar;
               framingError <= pendFrm;
               breakDetect  <= pendBrk;
               rxValid      <= 1'b1;
            end else begin
               overrunError <= 1'b1;
            end
         end else if (rxValid && rxReady) begin
            rxValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: directed scenarios plus a
// randomized frame run checked against a frame-level reference model.
module tb_serial_receiver;

   localparam int OS = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       sampleTick;
   logic       rx;
   logic [1:0] wordLength;
   logic       parityEnable;
   logic       parityOdd;
   logic [7:0] rxData;
   logic       rxValid;
   logic       rxReady;
   logic       parityError;
   logic       framingError;
   logic       breakDetect;
   logic       overrunError;
   logic       busy;

   int checks  = 0;
   int errors  = 0;
   int ovCount = 0;
   int tickDiv = 1;
   int tcnt    = 0;

   serial_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .sampleTick(sampleTick),
      .rx(rx),
      .wordLength(wordLength),
      .parityEnable(parityEnable),
      .parityOdd(parityOdd),
      .rxData(rxData),
      .rxValid(rxValid),
      .rxReady(rxReady),
      .parityError(parityError),
      .framingError(framingError),
      .breakDetect(breakDetect),
      .overrunError(overrunError),
      .busy(busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (overrunError === 1'b1) ovCount++;
   end

   initial begin
      sampleTick = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         tcnt = (tcnt + 1) % tickDiv;
         sampleTick = (tcnt == 0);
      end
   end

   // expected word and flags from the frame as sent on the line
   function automatic logic [10:0] model(input logic [7:0] d, input int len,
                                         input bit pe, input bit odd,
                                         input bit pbit, input bit stopb);
      logic [7:0] m;
      logic par, frm, brk;
      m   = d & 8'((1 << len) - 1);
      par = pe && ((($countones(m) + int'(pbit)) % 2) != int'(odd));
      frm = !stopb;
      brk = !stopb && (m == 8'h00) && !(pe && pbit);
      return {m, par, frm, brk};
   endfunction

   task automatic hold(input logic v);
      rx = v;
      repeat (OS * tickDiv) @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input int len, input bit pe,
                             input bit pbit, input bit stopb);
      hold(1'b0);
      for (int i = 0; i < len; i++) hold(d[i]);
      if (pe) hold(pbit);
      hold(stopb);
      rx = 1'b1;
   endtask

   task automatic cfg(input int len, input bit pe, input bit odd);
      wordLength   = 2'(len - 5);
      parityEnable = pe;
      parityOdd    = odd;
   endtask

   task automatic wait_valid(output bit to);
      int k = 0;
      @(negedge clock);
      while (!rxValid && k < 600) begin
         @(negedge clock);
         k++;
      end
      to = (rxValid !== 1'b1);
   endtask

   task automatic consume();
      @(posedge clock);
      #1 rxReady = 1'b1;
      @(posedge clock);
      #1 rxReady = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; rx = 1'b1; rxReady = 1'b0;
      cfg(8, 1'b0, 1'b0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({rxData, rxValid, parityError, framingError, breakDetect,
           overrunError, busy} !== 14'h0) begin
         errors++;
         $display("FAIL reset_state got %h %b%b%b%b%b%b want 00 000000",
                  rxData, rxValid, parityError, framingError, breakDetect,
                  overrunError, busy);
      end
   endtask

   // the line falls just after a clock edge; two synchroniser flops and
   // the idle start detect put that at clock 3, the stop sample lands 8+16*9
   // clocks later and the word appears one clock after that: clock 156
   task automatic test_latency();
      int k = 0;
      cfg(8, 1'b0, 1'b0);
      fork
         send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
         begin
            while (k < 400) begin
               @(negedge clock);
               k++;
               if (rxValid === 1'b1) break;
            end
         end
      join
      checks++;
      if (k !== 156) begin
         errors++;
         $display("FAIL latency got %0d want 156", k);
      end
      checks++;
      if ({rxData, parityError, framingError, breakDetect} !== {8'hA5, 3'b000}) begin
         errors++;
         $display("FAIL word_8n1 got %h %b%b%b want a5 000", rxData,
                  parityError, framingError, breakDetect);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_after got %b want 0", busy);
      end
      consume();
      checks++;
      if (rxValid !== 1'b0) begin
         errors++;
         $display("FAIL valid_drop got %b want 0", rxValid);
      end
   endtask

   task automatic test_parity();
      bit to;
      bit [1:0] pbits [3] = '{2'b00, 2'b01, 2'b11};
      bit [2:0] exp;
      for (int t = 0; t < 3; t++) begin
         cfg(7, 1'b1, pbits[t][1]);
         send_frame(8'h41, 7, 1'b1, pbits[t][0], 1'b1);
         wait_valid(to);
         exp = (t == 1) ? 3'b100 : 3'b000;
         checks++;
         if (to || {rxData, parityError, framingError, breakDetect} !== {8'h41, exp}) begin
            errors++;
            $display("FAIL parity_%0d got %h %b%b%b want 41 %b", t, rxData,
                     parityError, framingError, breakDetect, exp);
         end
         consume();
      end
   endtask

   task automatic test_glitch();
      bit sawBusy = 0;
      bit sawValid = 0;
      cfg(8, 1'b0, 1'b0);
      rx = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == 4) rx = 1'b1;
         @(negedge clock);
         if (busy === 1'b1) sawBusy = 1;
         if (rxValid === 1'b1) sawValid = 1;
      end
      checks++;
      if (!sawBusy || sawValid || busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch got busySeen=%b validSeen=%b busy=%b want 1 0 0",
                  sawBusy, sawValid, busy);
      end
   endtask

   task automatic test_framing();
      bit to;
      bit sawValid = 0;
      cfg(8, 1'b0, 1'b0);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
      wait_valid(to);
      checks++;
      if (to || {rxData, parityError, framingError, breakDetect} !== {8'h3C, 3'b010}) begin
         errors++;
         $display("FAIL framing got %h %b%b%b want 3c 010", rxData,
                  parityError, framingError, breakDetect);
      end
      consume();
      rx = 1'b0;
      wait_valid(to);
      checks++;
      if (to || {rxData, parityError, framingError, breakDetect} !== {8'h00, 3'b011}) begin
         errors++;
         $display("FAIL break got %h %b%b%b want 00 011", rxData,
                  parityError, framingError, breakDetect);
      end
      consume();
      for (int i = 0; i < 150; i++) begin
         @(negedge clock);
         if (rxValid === 1'b1) sawValid = 1;
      end
      checks++;
      if (sawValid || busy !== 1'b1) begin
         errors++;
         $display("FAIL break_hold got validSeen=%b busy=%b want 0 1",
                  sawValid, busy);
      end
      #1 rx = 1'b1;
      repeat (10) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || rxValid !== 1'b0) begin
         errors++;
         $display("FAIL break_exit got busy=%b valid=%b want 0 0", busy, rxValid);
      end
      #1;
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
      wait_valid(to);
      checks++;
      if (to || {rxData, framingError, breakDetect} !== {8'h5A, 2'b00}) begin
         errors++;
         $display("FAIL after_break got %h %b%b want 5a 00", rxData,
                  framingError, breakDetect);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      int ov0;
      bit v0;
      cfg(8, 1'b0, 1'b0);
      ov0 = ovCount;
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clock);
      checks++;
      if (ovCount - ov0 !== 1 || rxData !== 8'h11 || rxValid !== 1'b1) begin
         errors++;
         $display("FAIL overrun got ov=%0d data=%h valid=%b want 1 11 1",
                  ovCount - ov0, rxData, rxValid);
      end
      #1;
      ov0 = ovCount;
      fork
         send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
         begin
            repeat (155) @(posedge clock);
            #1 rxReady = 1'b1;
            v0 = rxValid;
            @(posedge clock);
            #1 rxReady = 1'b0;
            @(negedge clock);
            checks++;
            if (v0 !== 1'b1 || rxValid !== 1'b1 || rxData !== 8'h33 ||
                ovCount !== ov0) begin
               errors++;
               $display("FAIL same_clock got v=%b%b data=%h ov=%0d want 11 33 0",
                        v0, rxValid, rxData, ovCount - ov0);
            end
         end
      join
      consume();
   endtask

   task automatic test_reset_midframe();
      bit to;
      cfg(8, 1'b0, 1'b0);
      send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
      hold(1'b0);
      for (int i = 0; i < 4; i++) hold(1'b1);
      reset = 1'b1;
      rx = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({rxData, rxValid, parityError, framingError, breakDetect, busy} !== 13'h0) begin
         errors++;
         $display("FAIL midframe_reset got %h v=%b busy=%b want 00 0 0",
                  rxData, rxValid, busy);
      end
      repeat (40) @(posedge clock);
      #1;
      cfg(5, 1'b0, 1'b0);
      send_frame(8'hF5, 5, 1'b0, 1'b0, 1'b1);
      wait_valid(to);
      checks++;
      if (to || {rxData, parityError, framingError, breakDetect} !== {8'h15, 3'b000}) begin
         errors++;
         $display("FAIL word_5n1 got %h %b%b%b want 15 000", rxData,
                  parityError, framingError, breakDetect);
      end
   endtask

   task automatic test_enable();
      int ov0 = ovCount;
      bit sawBusy = 0;
      @(posedge clock);
      #1;
      cfg(8, 1'b0, 1'b0);
      hold(1'b0);
      hold(1'b1);
      hold(1'b0);
      hold(1'b1);
      enable = 1'b0;
      rx = 1'b1;
      repeat (2) @(posedge clock);
      #1 enable = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (busy === 1'b1) sawBusy = 1;
      end
      checks++;
      if (sawBusy || rxValid !== 1'b1 || rxData !== 8'h15 || ovCount !== ov0) begin
         errors++;
         $display("FAIL enable_abort got busy=%b v=%b data=%h ov=%0d want 0 1 15 0",
                  sawBusy, rxValid, rxData, ovCount - ov0);
      end
      consume();
   endtask

   task automatic test_random();
      bit to;
      logic [7:0] d;
      logic [10:0] exp;
      int len;
      bit pe, odd, pbit, stopb;
      for (int n = 0; n < 16; n++) begin
         #1;
         tickDiv = $urandom_range(1, 3);
         len   = $urandom_range(5, 8);
         pe    = 1'($urandom);
         odd   = 1'($urandom);
         pbit  = 1'($urandom);
         stopb = ($urandom_range(0, 3) != 0);
         d     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         cfg(len, pe, odd);
         exp = model(d, len, pe, odd, pbit, stopb);
         repeat (3 * OS) @(posedge clock);
         #1;
         send_frame(d, len, pe, pbit, stopb);
         wait_valid(to);
         checks++;
         if (to || {rxData, parityError, framingError, breakDetect} !== exp) begin
            errors++;
            $display("FAIL rand_%0d got %h %b%b%b want %h %b", n, rxData,
                     parityError, framingError, breakDetect, exp[10:3], exp[2:0]);
         end
         consume();
      end
      tickDiv = 1;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_parity();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_reset_midframe();
      test_enable();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
